vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_arbiter.sv | 137 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter for a 4x-scaled 160x120 RGB332 VGA display.
// Display fetches win every 4th visible pixel; writer requests fill the other cycles.
module vga_fb_arbiter #(
    parameter int unsigned HBP  = 144,
    parameter int unsigned VBP  = 31,
    parameter int unsigned FB_W = 160,
    parameter int unsigned FB_H = 120
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        vidon,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_req,
    input  logic [14:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_blank_only,
    output logic        wr_ack,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        frame_start
);

    localparam int unsigned ADDR_W = $clog2(FB_W * FB_H);
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned PIPE_N = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        WR   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [PIX_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic                wr_ack_q, wr_ack_d;
    logic [1:0]          vid_q;
    logic [PIPE_N-1:0]   hs_q, vs_q;
    logic                ld_q;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [PIX_W-1:0]    rgb_q, rgb_d;
    logic                fs_q;

    logic [9:0]          px;
    logic [7:0]          gx, gy;
    logic [ADDR_W-1:0]   disp_addr;
    logic                disp_slot;
    logic                wr_ok;

    // Scaled framebuffer address: gy*160 + gx as (gy<<7) + (gy<<5) + gx
    always_comb begin
        px        = hc - 10'(HBP);
        gx        = px[9:2];
        gy        = 8'((vc - 10'(VBP)) >> 2);
        disp_addr = ADDR_W'({gy, 7'b0}) + ADDR_W'({gy, 5'b0}) + ADDR_W'(gx);
        disp_slot = vidon && (px[1:0] == 2'b00);
        wr_ok     = wr_req && (state_q != WR) && (!wr_blank_only || !vidon);
    end

    // Next-state and registered memory-port values
    always_comb begin
        state_d     = IDLE;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_ack_d    = 1'b0;
        if (disp_slot) begin
            state_d    = DISP;
            mem_addr_d = disp_addr;
        end else if (wr_ok) begin
            state_d     = WR;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
            mem_we_d    = 1'b1;
            wr_ack_d    = 1'b1;
        end
    end

    // Pixel capture two cycles after a fetch; colour blanked by the delayed vidon
    always_comb begin
        pix_d = ld_q ? mem_rdata : pix_q;
        rgb_d = vid_q[1] ? pix_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            vid_q       <= '0;
            hs_q        <= '0;
            vs_q        <= '0;
            ld_q        <= 1'b0;
            pix_q       <= '0;
            rgb_q       <= '0;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wr_ack_q    <= wr_ack_d;
            vid_q       <= {vid_q[0], vidon};
            hs_q        <= {hs_q[PIPE_N-2:0], hsync_in};
            vs_q        <= {vs_q[PIPE_N-2:0], vsync_in};
            ld_q        <= (state_q == DISP);
            pix_q       <= pix_d;
            rgb_q       <= rgb_d;
            fs_q        <= (hc == 10'd0) && (vc == 10'd0);
        end
    end

    assign wr_ack      = wr_ack_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign hsync       = hs_q[PIPE_N-1];
    assign vsync       = vs_q[PIPE_N-1];
    assign red         = rgb_q[7:5];
    assign green       = rgb_q[4:2];
    assign blue        = rgb_q[1:0];
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: memory-port transactions are scored against a
// queue of expected accesses; pixel, sync and reset behaviour against constants.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [9:0]  hc, vc;
    logic        vidon, hsync_in, vsync_in;
    logic        wr_req, wr_blank_only;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        hsync, vsync;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic        frame_start;

    typedef struct packed {
        logic [14:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        ack;
    } mem_exp_t;

    mem_exp_t exp_q[$];
    int n_chk = 0;
    int n_err = 0;

    int dh[4] = '{144, 148, 144, 780};
    int dv[4] = '{31, 31, 35, 510};
    int da[4] = '{0, 1, 160, 19199};

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk(clk), .clr_n(clr_n), .hc(hc), .vc(vc), .vidon(vidon),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_blank_only(wr_blank_only), .wr_ack(wr_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .frame_start(frame_start)
    );

    // Synchronous-read RAM: address 0 holds 0xE3, address 1 holds 0x1C
    always @(posedge clk)
        mem_rdata <= (mem_addr == 15'd0) ? 8'hE3 : (mem_addr == 15'd1) ? 8'h1C : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int h, input int v, input int vid);
        hc    = 10'(h);
        vc    = 10'(v);
        vidon = 1'(vid);
    endtask

    task automatic push(input int a, input int we, input int d);
        mem_exp_t e;
        e.addr  = 15'(a);
        e.we    = 1'(we);
        e.wdata = 8'(d);
        e.ack   = 1'(we);
        exp_q.push_back(e);
    endtask

    task automatic chk_mem(input string tag);
        mem_exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL %s: got mem access addr=%0h want none", tag, mem_addr);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_addr"}, 32'(mem_addr), 32'(e.addr));
        chk({tag, "_we"},   32'(mem_we),   32'(e.we));
        chk({tag, "_ack"},  32'(wr_ack),   32'(e.ack));
        if (e.we) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(e.wdata));
    endtask

    initial begin
        int  k, cyc;
        int  acks;
        logic prev, got;

        clr_n = 1'b0; wr_req = 1'b0; wr_blank_only = 1'b0;
        wr_addr = '0; wr_data = '0; hsync_in = 1'b1; vsync_in = 1'b1;
        drv(0, 0, 0);
        tick(); tick();
        chk("rst_mem", 32'({mem_addr, mem_we, mem_wdata, wr_ack}), 32'd0);
        chk("rst_vid", 32'({hsync, vsync, red, green, blue, frame_start}), 32'd0);

        // Release: frame_start pulse and sync pipeline refill
        clr_n = 1'b1;
        tick();
        chk("fs_pulse", 32'(frame_start), 32'd1);
        chk("sync_fill1", 32'({hsync, vsync}), 32'd0);
        drv(1, 0, 0);
        tick();
        chk("fs_low", 32'(frame_start), 32'd0);
        chk("sync_fill2", 32'({hsync, vsync}), 32'd0);
        tick();
        chk("sync_fill3", 32'({hsync, vsync}), 32'd3);
        hsync_in = 1'b0; vsync_in = 1'b0;

        // Display fetch addresses
        for (int i = 0; i < 4; i++) begin
            drv(dh[i], dv[i], 1);
            push(da[i], 0, 0);
            tick();
            chk_mem("disp");
        end
        drv(145, 35, 1);
        push(19199, 0, 0);
        tick();
        chk_mem("idle_hold");

        // Pixel alignment: slot at cycle n, colour visible n+3..n+6, blanked after vidon drops
        drv(700, 31, 0);
        tick(); tick(); tick();
        for (int j = 1; j <= 11; j++) begin
            drv(144 + j - 1, 31, (j <= 8) ? 1 : 0);
            tick();
            chk($sformatf("pix_%0d", j), 32'({red, green, blue}),
                (j < 3) ? 32'h00 : (j < 7) ? 32'hE3 : (j < 11) ? 32'h1C : 32'h00);
        end

        // Collision: display wins, write follows, single ack
        drv(144, 31, 1);
        wr_req = 1'b1; wr_addr = 15'h1234; wr_data = 8'h55;
        push(0, 0, 0);
        tick();
        chk_mem("col_disp");
        push(15'h1234, 1, 8'h55);
        drv(145, 31, 1);
        tick();
        chk_mem("col_wr");
        drv(146, 31, 1);
        tick();
        chk("col_once", 32'({wr_ack, mem_we}), 32'd0);
        wr_req = 1'b0;
        drv(700, 200, 0);
        tick();

        // Back-to-back during blanking: new address after each ack
        k = 0; cyc = 0; prev = 1'b0;
        wr_addr = 15'h100; wr_data = 8'hA0; wr_req = 1'b1;
        push(32'h100, 1, 32'hA0);
        while (k < 4 && cyc < 20) begin
            tick();
            cyc++;
            if (wr_ack) begin
                chk_mem("b2b");
                chk("b2b_gap", 32'(prev), 32'd0);
                k++;
                wr_addr = 15'(256 + k);
                wr_data = 8'(160 + k);
                if (k < 4) push(256 + k, 1, 160 + k);
                else wr_req = 1'b0;
            end
            prev = wr_ack;
        end
        chk("b2b_count", 32'(k), 32'd4);
        chk("b2b_cycles", 32'(cyc), 32'd7);
        exp_q.delete();
        tick();

        // Blank-only: request held through active video, granted once vidon drops
        wr_blank_only = 1'b1; wr_req = 1'b1;
        wr_addr = 15'h0ABC; wr_data = 8'h77;
        push(15'h0ABC, 1, 8'h77);
        acks = 0;
        for (int h = 200; h < 784; h++) begin
            drv(h, 100, 1);
            tick();
            if (wr_ack) acks++;
        end
        chk("bo_hold", 32'(acks), 32'd0);
        drv(784, 100, 0);
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            tick();
            if (wr_ack) begin
                got = 1'b1;
                chk_mem("bo_wr");
            end
            drv(785 + i, 100, 0);
        end
        chk("bo_ack", 32'(got), 32'd1);
        exp_q.delete();
        wr_req = 1'b0; wr_blank_only = 1'b0;
        drv(700, 200, 0);
        tick();

        // Reset hits the edge that would present a granted write
        wr_req = 1'b1; wr_addr = 15'h2222; wr_data = 8'h33;
        clr_n = 1'b0; hsync_in = 1'b1;
        tick();
        chk("rm_mem", 32'({mem_addr, mem_we, mem_wdata, wr_ack}), 32'd0);
        chk("rm_vid", 32'({hsync, vsync, red, green, blue, frame_start}), 32'd0);
        tick();
        chk("rm_hold", 32'({mem_we, wr_ack, hsync}), 32'd0);
        clr_n = 1'b1; hsync_in = 1'b0;
        push(15'h2222, 1, 8'h33);
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            tick();
            if (wr_ack) begin
                got = 1'b1;
                chk_mem("rm_regrant");
            end
        end
        chk("rm_ack", 32'(got), 32'd1);
        exp_q.delete();
        wr_req = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
